// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NREQ byte producers.
// Optional watchdog on the SEND phase is enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NREQ          = 4,
    parameter int DBITS         = 8,
    parameter int GAP_TICKS     = 16,
    parameter int TIMEOUT_TICKS = 4096
) (
    input  logic                    clk_100MHz,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DBITS-1:0]   req_data,
    output logic [NREQ-1:0]         ack,
    input  logic                    tick,
    output logic                    tx_start,
    output logic [DBITS-1:0]        tx_data,
    input  logic                    tx_done_tick,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] owner
`ifdef UART_TX_ARB_TIMEOUT_EN
    ,
    output logic                    timeout_err
`endif
);

    // state  | meaning
    // IDLE   | waiting for any req; grant taken on the next edge
    // SEND   | byte handed to the UART, waiting for its done tick
    // GAP    | holding the line idle for GAP_TICKS sample ticks

    localparam int PW = $clog2(NREQ);
    localparam int IW = PW + 1;
    localparam int GW = $clog2(GAP_TICKS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [PW-1:0]     r_ptr, w_ptr_nxt;
    logic [PW-1:0]     r_owner;
    logic [GW-1:0]     r_gap, w_gap_nxt;
    logic [NREQ-1:0]   r_ack;
    logic              r_tx_start;
    logic [DBITS-1:0]  r_tx_data;

    logic [PW-1:0]     w_winner;
    logic              w_found;
    logic              w_grant;
    logic [IW-1:0]     w_idx;
    logic [DBITS-1:0]  w_sel;
    logic [NREQ-1:0]   w_onehot;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_TICKS + 1);
    logic [WW-1:0]     r_wd, w_wd_nxt;
    logic              r_timeout;
    logic              w_timeout;
`endif

    // Highest search distance first so the nearest requester from r_ptr wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = IW'(r_ptr) + IW'(k);
            if (w_idx >= IW'(NREQ)) begin
                w_idx = w_idx - IW'(NREQ);
            end
            if (req[w_idx[PW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[PW-1:0];
            end
        end
    end

    always_comb begin
        w_sel    = '0;
        w_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner == PW'(i)) begin
                w_sel       = req_data[i*DBITS +: DBITS];
                w_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gap_nxt   = r_gap;
        w_grant     = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
        w_wd_nxt    = r_wd;
        w_timeout   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_SEND;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    w_wd_nxt    = '0;
`endif
                end
            end
            S_SEND: begin
                // A done tick coincident with our own start pulse belongs to a stale frame.
                if (tx_done_tick && !r_tx_start) begin
                    w_state_nxt = S_GAP;
                    w_gap_nxt   = '0;
                end
`ifdef UART_TX_ARB_TIMEOUT_EN
                else if (tick) begin
                    if (r_wd == WW'(TIMEOUT_TICKS - 1)) begin
                        w_state_nxt = S_GAP;
                        w_gap_nxt   = '0;
                        w_timeout   = 1'b1;
                    end else begin
                        w_wd_nxt = r_wd + WW'(1);
                    end
                end
`endif
            end
            S_GAP: begin
                if (tick) begin
                    if (r_gap == GW'(GAP_TICKS - 1)) begin
                        w_state_nxt = S_IDLE;
                        w_ptr_nxt   = (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + PW'(1);
                    end else begin
                        w_gap_nxt = r_gap + GW'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_gap      <= '0;
            r_owner    <= '0;
            r_ack      <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            r_wd       <= '0;
            r_timeout  <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_gap      <= w_gap_nxt;
            r_ack      <= w_grant ? w_onehot : '0;
            r_tx_start <= w_grant;
            if (w_grant) begin
                r_tx_data <= w_sel;
                r_owner   <= w_winner;
            end
`ifdef UART_TX_ARB_TIMEOUT_EN
            r_wd       <= w_wd_nxt;
            r_timeout  <= w_timeout;
`endif
        end
    end

    assign ack      = r_ack;
    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
    assign owner    = r_owner;
    assign busy     = (r_state != S_IDLE);
`ifdef UART_TX_ARB_TIMEOUT_EN
    assign timeout_err = r_timeout;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected grants queued as requests are posted.
// Define UART_TX_ARB_TIMEOUT_EN to also exercise the watchdog with TIMEOUT_TICKS=8.
module tb_uart_tx_arbiter;

    localparam int NREQ      = 4;
    localparam int DBITS     = 8;
    localparam int GAP_TICKS = 16;
`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int TOT = 8;
`else
    localparam int TOT = 4096;
`endif

    logic                  clk_100MHz = 1'b0;
    logic                  reset_n = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*DBITS-1:0] req_data = '0;
    logic [NREQ-1:0]       ack;
    logic                  tick;
    logic                  tx_start;
    logic [DBITS-1:0]      tx_data;
    logic                  tx_done_tick;
    logic                  busy;
    logic [1:0]            owner;
`ifdef UART_TX_ARB_TIMEOUT_EN
    logic                  timeout_err;
`endif

    logic tick_a = 1'b0, tick_m = 1'b0, done_a = 1'b0, done_m = 1'b0;
    bit   tick_auto = 1'b0, done_auto = 1'b0;
    assign tick         = tick_a | tick_m;
    assign tx_done_tick = done_a | done_m;

    int n_checks = 0;
    int n_err    = 0;
    int posted[NREQ];
    int taken[NREQ];
    int exp_n[NREQ];
    int q_own[$];
    int q_dat[$];
    int n_start = 0;
    int gcnt = 0;
    bit in_frame = 1'b0, in_gap = 1'b0;

    uart_tx_arbiter #(
        .NREQ(NREQ), .DBITS(DBITS), .GAP_TICKS(GAP_TICKS), .TIMEOUT_TICKS(TOT)
    ) dut (
        .clk_100MHz  (clk_100MHz),
        .reset_n     (reset_n),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .tick        (tick),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_done_tick(tx_done_tick),
        .busy        (busy),
        .owner       (owner)
`ifdef UART_TX_ARB_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DBITS-1:0] byte_of(input int i, input int n);
        return DBITS'(i * 37 + n * 11 + 128);
    endfunction

    task automatic post(input int i);
        posted[i]++;
    endtask

    task automatic expect_g(input int i);
        q_own.push_back(i);
        q_dat.push_back(int'(byte_of(i, exp_n[i])));
        exp_n[i]++;
    endtask

    task automatic wait_q(input int budget, input string tag);
        int c = 0;
        while (q_own.size() != 0 && c < budget) begin
            @(negedge clk_100MHz); #1;
            c++;
        end
        check(tag, q_own.size(), 0);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int c = 0;
        while ((q_own.size() != 0 || busy) && c < budget) begin
            @(negedge clk_100MHz); #1;
            c++;
        end
        check(tag, q_own.size() + int'(busy), 0);
    endtask

    task automatic cyc();
        @(posedge clk_100MHz); #1;
    endtask

    // Requesters: hold req while bytes remain, present the next byte after each ack.
    initial begin
        forever begin
            @(posedge clk_100MHz); #1;
            for (int i = 0; i < NREQ; i++) begin
                req[i] = (posted[i] != taken[i]);
                req_data[i*DBITS +: DBITS] = byte_of(i, taken[i]);
            end
        end
    end

    initial begin
        bit ph = 1'b0;
        forever begin
            @(posedge clk_100MHz); #1;
            tick_a = tick_auto && ph;
            ph = !ph;
        end
    end

    initial begin
        forever begin
            @(negedge clk_100MHz);
            if (tx_start && done_auto) begin
                repeat (5) @(posedge clk_100MHz);
                #1 done_a = 1'b1;
                @(posedge clk_100MHz);
                #1 done_a = 1'b0;
            end
        end
    end

    // Output monitor and scoreboard.
    initial begin
        int eo, ed;
        forever begin
            @(negedge clk_100MHz);
            if (!reset_n) begin
                in_frame = 1'b0;
                in_gap   = 1'b0;
            end else begin
                if (in_gap && !busy) begin
                    check("gap_len", gcnt, GAP_TICKS);
                    in_gap = 1'b0;
                end
                if (tx_start) begin
                    check("frame_overlap", in_frame, 0);
                    check("busy_in_send", busy, 1);
                    in_frame = 1'b1;
                    n_start++;
                    if (q_own.size() == 0) begin
                        check("start_unexpected", q_own.size(), 1);
                    end else begin
                        eo = q_own.pop_front();
                        ed = q_dat.pop_front();
                        check("owner", owner, eo);
                        check("tx_data", tx_data, ed);
                        check("ack", ack, 32'(1) << eo);
                    end
                end else if (ack != '0) begin
                    check("ack_without_start", ack, 0);
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (ack[i]) taken[i]++;
                end
                if (in_frame && tx_done_tick && !tx_start) begin
                    in_frame = 1'b0;
                    in_gap   = 1'b1;
                    gcnt     = 0;
                end
`ifdef UART_TX_ARB_TIMEOUT_EN
                else if (in_frame && timeout_err) begin
                    in_frame = 1'b0;
                    in_gap   = 1'b1;
                    gcnt     = 0;
                end
`endif
                else if (in_gap && tick) begin
                    gcnt++;
                end
            end
        end
    end

    initial begin
        int s0;
        for (int i = 0; i < NREQ; i++) begin
            posted[i] = 0;
            taken[i]  = 0;
            exp_n[i]  = 0;
        end

        // Reset values
        repeat (3) @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        check("rst_ack", ack, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 0);
        cyc();
        reset_n   = 1'b1;
        tick_auto = 1'b1;
        done_auto = 1'b1;

        // Single requester 1 with 0xA5
        expect_g(1);
        post(1);
        wait_idle(500, "t1_idle");

        // All four from reset: 0,1,2,3,0,1,2,3
        cyc(); reset_n = 1'b0;
        cyc(); cyc(); reset_n = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                expect_g(i);
                post(i);
            end
        end
        wait_idle(3000, "t2_idle");

        // Pointer: owner 2, then req 0101 -> 0, then 1111 -> 1,2,3
        expect_g(2);
        post(2);
        wait_idle(500, "t3a_idle");
        expect_g(0);
        post(0);
        post(2);
        wait_q(200, "t3b_start");
        expect_g(1);
        expect_g(2);
        expect_g(3);
        post(1);
        post(3);
        wait_idle(2000, "t3c_idle");

        // Gap timing with manual ticks
        tick_auto = 1'b0;
        done_auto = 1'b0;
        expect_g(2);
        post(2);
        wait_q(200, "t4_start");
        s0 = n_start;
        repeat (3) cyc();
        done_m = 1'b1;
        cyc();
        done_m = 1'b0;
        expect_g(2);
        post(2);
        for (int k = 0; k < GAP_TICKS - 1; k++) begin
            tick_m = 1'b1;
            cyc();
            tick_m = 1'b0;
            cyc();
        end
        repeat (3) cyc();
        check("gap_no_start", n_start - s0, 0);
        check("gap_busy", busy, 1);
        tick_m = 1'b1;
        cyc();
        tick_m = 1'b0;
        @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        check("gap_restart", tx_start, 1);
        repeat (3) cyc();
        done_m = 1'b1;
        cyc();
        done_m = 1'b0;
        tick_auto = 1'b1;
        wait_idle(500, "t4_idle");

        // Reset two cycles after tx_start; pointer left at 3 beforehand
        done_auto = 1'b0;
        expect_g(2);
        post(2);
        wait_q(200, "t5_start");
        @(posedge clk_100MHz);
        @(posedge clk_100MHz);
        #1 reset_n = 1'b0;
        #1;
        check("arst_ack", ack, 0);
        check("arst_tx_start", tx_start, 0);
        check("arst_tx_data", tx_data, 0);
        check("arst_busy", busy, 0);
        check("arst_owner", owner, 0);
        repeat (2) @(posedge clk_100MHz);
        #1 reset_n = 1'b1;
        done_auto = 1'b1;
        expect_g(1);
        expect_g(3);
        post(1);
        post(3);
        wait_idle(1000, "t5_idle");

`ifdef UART_TX_ARB_TIMEOUT_EN
        // Watchdog: no done tick for requester 0, then requester 1 served
        begin
            int n_t = 0;
            done_auto = 1'b0;
            expect_g(0);
            expect_g(1);
            post(0);
            post(1);
            while (q_own.size() > 1 && n_t < 200) begin
                @(negedge clk_100MHz); #1;
                n_t++;
            end
            check("to_first_start", q_own.size(), 1);
            n_t = 0;
            for (int c = 0; c < 300; c++) begin
                if (timeout_err) break;
                if (tick) n_t++;
                @(negedge clk_100MHz); #1;
            end
            check("to_ticks", n_t, TOT);
            check("to_err", timeout_err, 1);
            check("to_busy_gap", busy, 1);
            done_auto = 1'b1;
            @(negedge clk_100MHz); #1;
            check("to_pulse_1cyc", timeout_err, 0);
            wait_idle(1000, "t6_idle");
        end
`endif

        repeat (5) cyc();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
